// File: rtl/zprize_mul_pkg.sv
// rtl/zprize_mul_pkg.sv - shared widths and FIFO entry layout for the multiplier receive path
package zprize_mul_pkg;

  localparam int DEF_W  = 384;
  localparam int DEF_M  = 32;
  localparam int PROD_W = 2 * DEF_W;

  typedef struct packed {
    logic [DEF_M-1:0]  m;
    logic [PROD_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/zprize_sdp_ram.sv
// rtl/zprize_sdp_ram.sv - simple dual-port RAM, one write port and one registered read port
module zprize_sdp_ram #(
  parameter int DEPTH = 16,
  parameter int DW    = 800,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Read-during-write to the same address returns the old word; the caller bypasses it.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/zprize_mul_rx.sv
// rtl/zprize_mul_rx.sv - credit-controlled product FIFO between the multiplier and reduction
// Defining ZPRIZE_MUL_RX_ERR_EN adds a sticky protocol-error output err.
module zprize_mul_rx
  import zprize_mul_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int M     = DEF_M,
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue,
  output logic            issue_ok,
  input  logic            prod_v,
  input  logic [2*W-1:0]  prod,
  input  logic [M-1:0]    prod_m,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [2*W-1:0]  out_data,
  output logic [M-1:0]    out_m,
  output logic [CW-1:0]   in_flight,
  output logic [CW-1:0]   level
`ifdef ZPRIZE_MUL_RX_ERR_EN
  ,
  output logic            err
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int EW = 2 * W + M;
  localparam logic [CW:0] CAP = DEPTH[CW:0];

  logic          push, pop, sel_byp;
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [EW-1:0] byp_q, ram_q;

  assign push       = prod_v;
  assign pop        = out_valid && out_ready;
  assign rd_ptr_nxt = rd_ptr + AW'(pop);
  assign out_valid  = (level != '0);
  assign issue_ok   = ({1'b0, in_flight} + {1'b0, level}) < CAP;
  assign {out_m, out_data} = sel_byp ? byp_q : ram_q;

  // The RAM always reads the next head address so a pop shows the following entry one cycle later.
  zprize_sdp_ram #(.DEPTH(DEPTH), .DW(EW), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata ({prod_m, prod}),
    .raddr (rd_ptr_nxt),
    .rdata (ram_q)
  );

  always_ff @(posedge clk) begin
    if (push) byp_q <= {prod_m, prod};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      sel_byp   <= 1'b0;
      in_flight <= '0;
      level     <= '0;
    end else begin
      wr_ptr  <= wr_ptr + AW'(push);
      rd_ptr  <= rd_ptr_nxt;
      // A word written into the slot about to become head is not yet visible through the RAM read.
      sel_byp <= push && (wr_ptr == rd_ptr_nxt);
      case ({issue, prod_v})
        2'b10:   in_flight <= in_flight + CW'(1);
        2'b01:   in_flight <= in_flight - CW'(1);
        default: in_flight <= in_flight;
      endcase
      case ({push, pop})
        2'b10:   level <= level + CW'(1);
        2'b01:   level <= level - CW'(1);
        default: level <= level;
      endcase
    end
  end

`ifdef ZPRIZE_MUL_RX_ERR_EN
  logic viol;
  assign viol = (issue && !issue_ok) || (prod_v && in_flight == '0) ||
                (push && level == CAP[CW-1:0]);

  always_ff @(posedge clk) begin
    if (rst) err <= 1'b0;
    else if (viol) err <= 1'b1;
  end

  assert_clk: assert property (@(posedge clk) disable iff (rst) !viol);
`endif

endmodule
